// File: rtl/fft_out_collector_if.sv
// fft_out_collector_if
// Bundles the two streams around the FFT output collector:
//   in_real/in_img/in_valid/in_done : sample stream from the FFT core.
//   out_real/out_img/out_power/out_index/out_valid/out_ready/out_last :
//     natural-order bin stream to the downstream consumer.
// Modports:
//   slave  - the collector (consumes the FFT stream, produces bins)
//   master - the environment (drives FFT samples, accepts bins)
interface fft_out_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LENGTH = 16
) ();
  localparam int LOG2 = $clog2(SEQ_LENGTH);

  logic [DATA_WIDTH-1:0]   in_real;
  logic [DATA_WIDTH-1:0]   in_img;
  logic                    in_valid;
  logic                    in_done;

  logic [DATA_WIDTH-1:0]   out_real;
  logic [DATA_WIDTH-1:0]   out_img;
  logic [2*DATA_WIDTH:0]   out_power;
  logic [LOG2-1:0]         out_index;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport slave (
    input  in_real, in_img, in_valid, in_done, out_ready,
    output out_real, out_img, out_power, out_index, out_valid, out_last
  );

  modport master (
    output in_real, in_img, in_valid, in_done, out_ready,
    input  out_real, out_img, out_power, out_index, out_valid, out_last
  );
endinterface

// File: rtl/fft_out_collector.sv
// fft_out_collector
// Captures one frame of SEQ_LENGTH FFT output samples (optionally in
// bit-reversed order), then streams the bins out in natural order with
// a valid/ready handshake together with each bin's power re^2 + im^2.
// Ports:
//   clk         - sole clock, rising edge
//   reset_n     - asynchronous active-low reset
//   bus         - fft_out_collector_if.slave (FFT input + bin output streams)
//   busy        - high while capturing or draining
//   frame_done  - one-cycle pulse after the last bin transfers
//   overflow    - sticky: a sample arrived while draining
//   short_frame - sticky: in_done arrived before a full frame was captured
module fft_out_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int SEQ_LENGTH  = 16,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fft_out_collector_if.slave    bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  short_frame
);
  localparam int LOG2 = $clog2(SEQ_LENGTH);
  localparam int CW   = LOG2 + 1;
  localparam int PW   = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wr_cnt_reg;
  logic [LOG2-1:0] rd_ptr_reg;

  logic            wr_en, load_first, advance, finish, set_ovf, set_short;
  logic            xfer;
  logic [LOG2-1:0] wr_idx, wr_idx_rev, wr_addr, rd_next, rd_addr;

  logic [PW-1:0]   mem [SEQ_LENGTH];
  logic [PW-1:0]   rd_word;

  logic signed [DATA_WIDTH-1:0] rd_re, rd_im;
  logic signed [PW-1:0]         sq_re, sq_im;
  logic [PW:0]                  rd_power;

  assign xfer = bus.out_valid && bus.out_ready;
  assign busy = (state_reg != IDLE);

  // Next-state and control strobes
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    set_ovf    = 1'b0;
    set_short  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          wr_en      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_reg == CW'(SEQ_LENGTH - 1)) begin
            // Final sample: present bin 0 on the very next cycle.
            load_first = 1'b1;
            state_next = DRAIN;
          end
        end else if (bus.in_done) begin
          set_short  = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // Samples arriving here (even on the final transfer) are dropped.
        if (bus.in_valid) set_ovf = 1'b1;
        if (xfer) begin
          if (bus.out_last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Write address: sample count, optionally bit-reversed
  assign wr_idx = wr_cnt_reg[LOG2-1:0];
  for (genvar gi = 0; gi < LOG2; gi++) begin : g_rev
    assign wr_idx_rev[gi] = wr_idx[LOG2-1-gi];
  end
  assign wr_addr = (BIT_REVERSE != 0) ? wr_idx_rev : wr_idx;

  // Sample buffer; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {bus.in_real, bus.in_img};
  end

  // Read side: fetch the bin about to be presented
  assign rd_next = rd_ptr_reg + LOG2'(1);
  assign rd_addr = load_first ? '0 : rd_next;
  assign rd_word = mem[rd_addr];
  assign rd_re   = rd_word[PW-1:DATA_WIDTH];
  assign rd_im   = rd_word[DATA_WIDTH-1:0];
  // Sign-extended full-width squares; each is non-negative and fits in PW
  // bits, so the sum needs exactly one extra bit.
  assign sq_re    = PW'(rd_re) * PW'(rd_re);
  assign sq_im    = PW'(rd_im) * PW'(rd_im);
  assign rd_power = {1'b0, sq_re} + {1'b0, sq_im};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_reg    <= '0;
      rd_ptr_reg    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_real  <= '0;
      bus.out_img   <= '0;
      bus.out_power <= '0;
      bus.out_index <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
      short_frame   <= 1'b0;
    end else begin
      frame_done <= finish;
      if (set_ovf)   overflow    <= 1'b1;
      if (set_short) short_frame <= 1'b1;

      if (set_short || load_first) wr_cnt_reg <= '0;
      else if (wr_en)              wr_cnt_reg <= wr_cnt_reg + CW'(1);

      if (load_first || advance) begin
        // Output registers only change when a new bin is presented, so
        // they hold steady under backpressure.
        bus.out_real  <= rd_word[PW-1:DATA_WIDTH];
        bus.out_img   <= rd_word[DATA_WIDTH-1:0];
        bus.out_power <= rd_power;
        bus.out_index <= rd_addr;
        bus.out_last  <= (rd_addr == LOG2'(SEQ_LENGTH - 1));
        bus.out_valid <= 1'b1;
        rd_ptr_reg    <= rd_addr;
      end else if (finish) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        rd_ptr_reg    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fft_out_collector.sv
// tb_fft_out_collector
// Directed bench for fft_out_collector (16-bit samples, 16-point frames,
// bit-reversed capture). A table of hand-computed vectors covers the basic
// bit-reverse frame; hand-written sequences cover power/sign, gaps and
// backpressure, short frames, overflow and reset during drain.
module tb_fft_out_collector;
  localparam int DW = 16;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic busy, frame_done, overflow, short_frame;

  fft_out_collector_if #(.DATA_WIDTH(DW), .SEQ_LENGTH(N)) bus ();

  fft_out_collector #(.DATA_WIDTH(DW), .SEQ_LENGTH(N), .BIT_REVERSE(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .short_frame (short_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int in_re;
    int in_im;
    int exp_re;
    int exp_im;
    int exp_idx;
    bit exp_last;
  } vec_t;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev4(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if (k[b]) r = r | (1 << (3 - b));
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_short_frame"}, short_frame, 0);
    chk({tag, "_out_real"}, bus.out_real, 0);
    chk({tag, "_out_img"}, bus.out_img, 0);
    chk({tag, "_out_power"}, bus.out_power, 0);
    chk({tag, "_out_index"}, bus.out_index, 0);
  endtask

  // Samples given in FFT output order; expected bin k is sample bitrev(k).
  task automatic make_exp(input int re[N], input int im[N],
                          output int ere[N], output int eim[N]);
    for (int k = 0; k < N; k++) begin
      ere[k] = re[bitrev4(k)];
      eim[k] = im[bitrev4(k)];
    end
  endtask

  task automatic send_frame(input int re[N], input int im[N],
                            input int gap_every, input string tag);
    for (int n = 0; n < N; n++) begin
      bus.in_real  = DW'(re[n]);
      bus.in_img   = DW'(im[n]);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      if (n != N - 1) chk({tag, "_cap_no_valid"}, bus.out_valid, 0);
      if (gap_every > 0 && (n % gap_every) == gap_every - 1 && n != N - 1) begin
        step();
        chk({tag, "_gap_no_valid"}, bus.out_valid, 0);
        chk({tag, "_gap_busy"}, busy, 1);
      end
    end
    chk({tag, "_first_valid_lat"}, bus.out_valid, 1);
  endtask

  task automatic drain(input int ere[N], input int eim[N], input int stall_bin,
                       input int stall_n, input int ovf_bin, input int stop_bin,
                       input string tag);
    logic [DW-1:0] held_re;
    logic [DW-1:0] held_im;
    for (int k = 0; k < N; k++) begin
      if (k == stop_bin) return;
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_index"}, bus.out_index, k);
      chk({tag, "_real"}, $signed(bus.out_real), ere[k]);
      chk({tag, "_img"}, $signed(bus.out_img), eim[k]);
      chk({tag, "_power"}, bus.out_power,
          longint'(ere[k]) * ere[k] + longint'(eim[k]) * eim[k]);
      chk({tag, "_last"}, bus.out_last, (k == N - 1) ? 1 : 0);
      $display("%s bin %0d re %0d im %0d power %0d", tag, bus.out_index,
               $signed(bus.out_real), $signed(bus.out_img), bus.out_power);
      if (k == stall_bin) begin
        held_re = bus.out_real;
        held_im = bus.out_img;
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          chk({tag, "_stall_valid"}, bus.out_valid, 1);
          chk({tag, "_stall_real"}, bus.out_real, held_re);
          chk({tag, "_stall_img"}, bus.out_img, held_im);
          chk({tag, "_stall_index"}, bus.out_index, k);
        end
        bus.out_ready = 1'b1;
      end
      if (k == ovf_bin) begin
        bus.in_real  = 16'h1234;
        bus.in_img   = 16'h4321;
        bus.in_valid = 1'b1;
      end
      step();
      bus.in_valid = 1'b0;
    end
    chk({tag, "_frame_done"}, frame_done, 1);
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_busy_end"}, busy, 0);
    step();
    chk({tag, "_frame_done_pulse"}, frame_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[N];
    int   exp_order[N];
    int   re[N], im[N], ere[N], eim[N];

    bus.in_real   = '0;
    bus.in_img    = '0;
    bus.in_valid  = 1'b0;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    // Bit-reverse capture: sample n = (n, -n)
    exp_order = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < N; i++)
      tbl[i] = '{i, -i, exp_order[i], -exp_order[i], i, (i == N - 1)};
    for (int i = 0; i < N; i++) begin
      bus.in_real  = DW'(tbl[i].in_re);
      bus.in_img   = DW'(tbl[i].in_im);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("tbl_valid", bus.out_valid, 1);
      chk("tbl_real", $signed(bus.out_real), tbl[i].exp_re);
      chk("tbl_img", $signed(bus.out_img), tbl[i].exp_im);
      chk("tbl_index", bus.out_index, tbl[i].exp_idx);
      chk("tbl_last", bus.out_last, tbl[i].exp_last);
      $display("tbl bin %0d re %0d im %0d", bus.out_index,
               $signed(bus.out_real), $signed(bus.out_img));
      step();
    end
    chk("tbl_frame_done", frame_done, 1);
    chk("tbl_valid_drop", bus.out_valid, 0);
    step();
    chk("tbl_frame_done_pulse", frame_done, 0);

    // in_done while idle is ignored
    bus.in_done = 1'b1;
    step();
    bus.in_done = 1'b0;
    chk("idle_done_short", short_frame, 0);
    chk("idle_done_busy", busy, 0);

    // Power and sign: bin 0 = (256,256), bin 5 = (-3,4)
    for (int n = 0; n < N; n++) begin
      re[n] = n - 8;
      im[n] = 3 * n;
    end
    re[bitrev4(0)] = 256;  im[bitrev4(0)] = 256;
    re[bitrev4(5)] = -3;   im[bitrev4(5)] = 4;
    make_exp(re, im, ere, eim);
    send_frame(re, im, 0, "pwr");
    chk("pwr_bin0", bus.out_power, 131072);
    drain(ere, eim, -1, 0, -1, -1, "pwr");

    // Input gaps during capture plus 3-cycle backpressure at bin 2
    for (int n = 0; n < N; n++) begin
      re[n] = n * 37 - 300;
      im[n] = 1000 - n * 91;
    end
    make_exp(re, im, ere, eim);
    send_frame(re, im, 3, "bp");
    drain(ere, eim, 2, 3, -1, -1, "bp");

    // Short frame: 10 samples then in_done
    for (int n = 0; n < 10; n++) begin
      bus.in_real  = DW'(n + 100);
      bus.in_img   = DW'(n);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b1;
    step();
    bus.in_done  = 1'b0;
    chk("short_flag", short_frame, 1);
    chk("short_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      chk("short_no_valid", bus.out_valid, 0);
      step();
    end
    for (int n = 0; n < N; n++) begin
      re[n] = 500 - 7 * n;
      im[n] = -20 * n;
    end
    make_exp(re, im, ere, eim);
    send_frame(re, im, 0, "after_short");
    drain(ere, eim, -1, 0, -1, -1, "after_short");
    chk("short_sticky", short_frame, 1);

    // Overflow in mid-drain, then on the final transfer
    for (int n = 0; n < N; n++) begin
      re[n] = -1000 + 111 * n;
      im[n] = 32767 - n;
    end
    make_exp(re, im, ere, eim);
    send_frame(re, im, 0, "ovf");
    chk("ovf_before", overflow, 0);
    drain(ere, eim, -1, 0, 4, -1, "ovf");
    chk("ovf_flag", overflow, 1);
    send_frame(re, im, 0, "ovf_last");
    drain(ere, eim, -1, 0, N - 1, -1, "ovf_last");
    chk("ovf_last_no_restart", busy, 0);
    chk("ovf_last_no_valid", bus.out_valid, 0);

    // Reset during drain while bin 7 is presented
    for (int n = 0; n < N; n++) begin
      re[n] = 4 * n + 1;
      im[n] = -32768 + n;
    end
    make_exp(re, im, ere, eim);
    send_frame(re, im, 0, "rst");
    drain(ere, eim, -1, 0, -1, 7, "rst");
    chk("rst_pre_index", bus.out_index, 7);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_no_frame_done", frame_done, 0);
      chk("rst_no_valid", bus.out_valid, 0);
    end
    for (int n = 0; n < N; n++) begin
      re[n] = 9 * n - 60;
      im[n] = 2 * n + 5;
    end
    make_exp(re, im, ere, eim);
    send_frame(re, im, 0, "post_rst");
    drain(ere, eim, -1, 0, -1, -1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
